// File: rtl/lfsr_rng_arbiter_if.sv
// Request/grant/random-data bundle between consumers (master) and the shared LFSR arbiter (slave).
// Grants and data are one-cycle pulses; requesters hold req until their pulse, with no other backpressure.
interface lfsr_rng_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic            rnd_valid;
  logic [7:0]      rnd_data;
  logic            seed_load;
  logic [7:0]      seed_data;
  logic            busy;
  logic [7:0]      lfsr_state;

  modport master (
    output req, seed_load, seed_data,
    input  gnt, rnd_valid, rnd_data, busy, lfsr_state
  );

  modport slave (
    input  req, seed_load, seed_data,
    output gnt, rnd_valid, rnd_data, busy, lfsr_state
  );
endinterface

// File: rtl/lfsr_rng_arbiter.sv
// Round-robin share of one 8-bit Fibonacci LFSR; each grant shifts STEPS times and then pulses one byte.
// Latency STEPS+1 cycles from the IDLE cycle that accepts req; one delivery every STEPS+2 cycles.
module lfsr_rng_arbiter #(
  parameter int         NREQ     = 4,
  parameter int         STEPS    = 2,
  parameter logic [7:0] RST_SEED = 8'hAD
) (
  input  logic                clk,
  input  logic                rst,
  lfsr_rng_arbiter_if.slave   bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [NREQ-1:0] GNT_ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, STEP, DELIVER} state_t;

  state_t          state, state_nx;
  logic [7:0]      lfsr;
  logic [7:0]      lfsr_nx;
  logic [3:0]      cnt;
  logic [IW-1:0]   last;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;
  logic            pick_vld;
  logic [NREQ-1:0] gnt_q;
  logic            vld_q;
  logic [7:0]      data_q;

  assign lfsr_nx = {lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3], lfsr[7:1]};

  // Search starts just after the last winner so it drops to lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(last) + i) % NREQ);
      if (!pick_vld && bus.req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (!bus.seed_load && pick_vld) state_nx = STEP;
      STEP:    if (cnt == 4'd1) state_nx = DELIVER;
      DELIVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr    <= RST_SEED;
      cnt     <= '0;
      last    <= IW'(NREQ - 1);
      win_idx <= '0;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      gnt_q <= '0;
      vld_q <= 1'b0;
      case (state)
        IDLE: begin
          // A zero seed would lock the LFSR, so it falls back to the reset seed.
          if (bus.seed_load) begin
            lfsr <= (bus.seed_data == 8'd0) ? RST_SEED : bus.seed_data;
          end else if (pick_vld) begin
            win_idx <= pick_idx;
            cnt     <= 4'(STEPS);
          end
        end
        STEP: begin
          lfsr <= lfsr_nx;
          cnt  <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            gnt_q  <= GNT_ONE << win_idx;
            vld_q  <= 1'b1;
            data_q <= lfsr_nx;
          end
        end
        DELIVER: last <= win_idx;
        default: ;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rnd_valid  = vld_q;
  assign bus.rnd_data   = data_q;
  assign bus.busy       = (state != IDLE);
  assign bus.lfsr_state = lfsr;
endmodule
